fetch_decode: RTL and testbench

Front-end instruction issue stage for the single-issue RV32I core. It fetches instruction words from instruction memory over a ready-based request handshake and decodes them into `op_code`/`funct3`/`funct7` and the two ALU operands. It presents each decoded instruction to the execute stage with a valid/ready handshake. It also owns the program counter, computing the next PC from the ALU's branch result for B-type instructions and from the ALU's sum for JAL/JALR.

---
 rtl/fetch_decode.sv | 159 +++++++++++++++
 tb/tb_fetch_decode.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode.sv
// RV32I front end: fetches from instruction memory, decodes fields and
// operands, issues to execute and owns the program counter.
module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rs1_value,
  input  logic [31:0] rs2_value,
  output logic [6:0]  op_code,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] input1_value,
  output logic [31:0] input2_value,
  input  logic [31:0] alu_output_value,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [31:0] pc,
  output logic        illegal_instr
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    ISSUE
  } state_t;

  state_t      state;
  logic [31:0] instr;

  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [31:0] op1_d, op2_d;
  logic        legal;
  logic [31:0] pc_plus4, npc_raw, next_pc, seq_pc;

  assign imem_addr = pc;
  assign op_code   = instr[6:0];
  assign rd_addr   = instr[11:7];
  assign funct3    = instr[14:12];
  assign rs1_addr  = instr[19:15];
  assign rs2_addr  = instr[24:20];
  assign funct7    = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};

  always_comb begin
    legal = 1'b1;
    op1_d = rs1_value;
    op2_d = rs2_value;
    unique case (op_code)
      OP_R, OP_B: ;
      OP_I, OP_LOAD, OP_JALR: op2_d = imm_i;
      OP_S: op2_d = imm_s;
      OP_JAL: begin
        op1_d = pc;
        op2_d = imm_j;
      end
      OP_AUIPC: begin
        op1_d = pc;
        op2_d = imm_u;
      end
      OP_LUI: begin
        op1_d = {12'b0, instr[31:12]};
        op2_d = '0;
      end
      default: legal = 1'b0;
    endcase
  end

  // Branches use the ALU only as the taken condition; target is local.
  always_comb begin
    pc_plus4 = pc + 32'd4;
    npc_raw  = pc_plus4;
    unique case (op_code)
      OP_B: begin
        if (alu_output_value != '0)
          npc_raw = pc + imm_b;
      end
      OP_JAL:  npc_raw = alu_output_value;
      OP_JALR: npc_raw = alu_output_value & ~32'd1;
      default: npc_raw = pc_plus4;
    endcase
  end

  assign next_pc = {npc_raw[31:2], 2'b00};
  assign seq_pc  = {pc_plus4[31:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      instr         <= '0;
      input1_value  <= '0;
      input2_value  <= '0;
      imem_req      <= 1'b0;
      issue_valid   <= 1'b0;
      illegal_instr <= 1'b0;
    end else begin
      illegal_instr <= 1'b0;
      unique case (state)
        FETCH: begin
          if (imem_req && imem_ready) begin
            instr    <= imem_rdata;
            imem_req <= 1'b0;
            state    <= DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        DECODE: begin
          if (legal) begin
            input1_value <= op1_d;
            input2_value <= op2_d;
            issue_valid  <= 1'b1;
            state        <= ISSUE;
          end else begin
            illegal_instr <= 1'b1;
            pc            <= seq_pc;
            imem_req      <= 1'b1;
            state         <= FETCH;
          end
        end
        ISSUE: begin
          if (issue_ready) begin
            issue_valid <= 1'b0;
            pc          <= next_pc;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Randomized bench for fetch_decode: acts as instruction memory, register
// file and execute stage, checking against an instruction-encoder model.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_value, rs2_value;
  logic [6:0]  op_code;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] input1_value, input2_value;
  logic [31:0] alu_output_value;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] pc;
  logic        illegal_instr;

  fetch_decode #(.RESET_PC(32'h0)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rd_addr(rd_addr),
    .rs1_value(rs1_value),
    .rs2_value(rs2_value),
    .op_code(op_code),
    .funct3(funct3),
    .funct7(funct7),
    .input1_value(input1_value),
    .input2_value(input2_value),
    .alu_output_value(alu_output_value),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .pc(pc),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  logic [31:0] rf [32];
  logic [31:0] mpc;
  int errors = 0;
  int checks = 0;
  int hs_count = 0;
  int exp_issues = 0;

  always_comb begin
    rs1_value = rf[rs1_addr];
    rs2_value = rf[rs2_addr];
  end

  always @(posedge clk)
    if (!reset && issue_valid && issue_ready) hs_count++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                      7'h6F, 7'h67, 7'h17, 7'h37};
  endfunction

  task automatic run_instr(input logic [31:0] ins, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] alu,
                           input bit lg, input logic [31:0] npc,
                           input int fst, input int ist);
    int t = 0;
    while (!imem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("req_wait", {31'b0, imem_req}, 32'd1);
    if (!imem_req) return;
    chk("imem_addr", imem_addr, mpc);
    for (int i = 0; i < fst; i++) begin
      issue_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("stall_addr", imem_addr, mpc);
      chk("stall_req", {31'b0, imem_req}, 32'd1);
    end
    imem_ready = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    chk("op_code", {25'b0, op_code}, {25'b0, ins[6:0]});
    chk("funct3", {29'b0, funct3}, {29'b0, ins[14:12]});
    chk("funct7", {25'b0, funct7}, {25'b0, ins[31:25]});
    chk("rd_addr", {27'b0, rd_addr}, {27'b0, ins[11:7]});
    chk("rs1_addr", {27'b0, rs1_addr}, {27'b0, ins[19:15]});
    chk("rs2_addr", {27'b0, rs2_addr}, {27'b0, ins[24:20]});
    chk("dec_valid", {31'b0, issue_valid}, 32'd0);
    issue_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    issue_ready = 1'b0;
    if (!lg) begin
      chk("illegal_pulse", {31'b0, illegal_instr}, 32'd1);
      chk("illegal_valid", {31'b0, issue_valid}, 32'd0);
      mpc = npc;
      @(negedge clk);
      chk("illegal_clear", {31'b0, illegal_instr}, 32'd0);
      chk("illegal_valid2", {31'b0, issue_valid}, 32'd0);
      return;
    end
    chk("issue_valid", {31'b0, issue_valid}, 32'd1);
    chk("illegal_low", {31'b0, illegal_instr}, 32'd0);
    chk("input1", input1_value, e1);
    chk("input2", input2_value, e2);
    for (int i = 0; i < ist; i++) begin
      alu_output_value = $urandom;
      @(negedge clk);
      chk("hold_valid", {31'b0, issue_valid}, 32'd1);
      chk("hold_in1", input1_value, e1);
      chk("hold_in2", input2_value, e2);
      chk("hold_op", {25'b0, op_code}, {25'b0, ins[6:0]});
      chk("hold_pc", pc, mpc);
    end
    issue_ready = 1'b1;
    alu_output_value = alu;
    @(negedge clk);
    issue_ready = 1'b0;
    alu_output_value = $urandom;
    exp_issues++;
    mpc = npc;
    chk("post_valid", {31'b0, issue_valid}, 32'd0);
    chk("next_pc", pc, mpc);
  endtask

  task automatic rand_instr();
    logic [31:0] ins, e1, e2, alu, npc, iv;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    bit          lg;
    int          k;
    rd = 5'($urandom);
    r1 = 5'($urandom);
    r2 = 5'($urandom);
    f3 = 3'($urandom);
    f7 = 7'($urandom);
    alu = $urandom;
    lg = 1'b1;
    npc = (mpc + 32'd4) & ~32'd3;
    iv = $urandom;
    e1 = rf[r1];
    e2 = rf[r2];
    ins = '0;
    k = $urandom_range(0, 9);
    case (k)
      0: ins = {f7, r2, r1, f3, rd, 7'h33};
      1, 2, 3: begin
        op = (k == 1) ? 7'h13 : (k == 2) ? 7'h03 : 7'h67;
        iv = $urandom_range(0, 4095) - 2048;
        ins = {iv[11:0], r1, f3, rd, op};
        e2 = iv;
        if (k == 3) npc = alu & ~32'd3;
      end
      4: begin
        iv = $urandom_range(0, 4095) - 2048;
        ins = {iv[11:5], r2, r1, f3, iv[4:0], 7'h23};
        e2 = iv;
      end
      5: begin
        iv = ($urandom_range(0, 4095) - 2048) * 2;
        ins = {iv[12], iv[10:5], r2, r1, f3, iv[4:1], iv[11], 7'h63};
        if ($urandom_range(0, 1) == 0) alu = 0;
        npc = ((alu != 0) ? mpc + iv : mpc + 32'd4) & ~32'd3;
      end
      6: begin
        iv = ($urandom_range(0, 1048575) - 524288) * 2;
        ins = {iv[20], iv[10:1], iv[11], iv[19:12], rd, 7'h6F};
        e1 = mpc;
        e2 = iv;
        npc = alu & ~32'd3;
      end
      7: begin
        ins = {iv[19:0], rd, 7'h17};
        e1 = mpc;
        e2 = {iv[19:0], 12'b0};
      end
      8: begin
        ins = {iv[19:0], rd, 7'h37};
        e1 = {12'b0, iv[19:0]};
        e2 = 0;
      end
      default: begin
        op = 7'($urandom);
        while (is_legal(op)) op = 7'($urandom);
        ins = {iv[31:7], op};
        lg = 1'b0;
      end
    endcase
    run_instr(ins, e1, e2, alu, lg, npc,
              $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = '0;
    issue_ready = 1'b0;
    alu_output_value = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = '0;
    mpc = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'b0, issue_valid}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_op", {25'b0, op_code}, 32'd0);
    chk("rst_in1", input1_value, 32'd0);
    chk("rst_in2", input2_value, 32'd0);
    chk("rst_illegal", {31'b0, illegal_instr}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_req", {31'b0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);

    run_instr(32'h00500093, 32'h0, 32'd5, 32'h0, 1'b1, 32'h4, 0, 0);
    run_instr(32'h010000EF, 32'h4, 32'd16, 32'h10, 1'b1, 32'h10, 0, 0);
    run_instr(32'h00000463, 32'h0, 32'h0, 32'h1, 1'b1, 32'h18, 0, 0);
    run_instr(32'h010000EF, 32'h18, 32'd16, 32'h10, 1'b1, 32'h10, 0, 0);
    run_instr(32'h00000463, 32'h0, 32'h0, 32'h0, 1'b1, 32'h14, 0, 0);
    run_instr(32'h12345137, 32'h00012345, 32'h0, 32'h0, 1'b1, 32'h18, 0, 0);
    run_instr(32'h00500093, 32'h0, 32'd5, 32'h0, 1'b1, 32'h1C, 5, 4);
    run_instr(32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 1'b0, 32'h20, 0, 0);

    for (int n = 0; n < 150; n++) rand_instr();

    // Abort an instruction while it sits in ISSUE.
    while (!imem_req) @(negedge clk);
    imem_ready = 1'b1;
    imem_rdata = 32'h00500093;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", {31'b0, issue_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, issue_valid}, 32'd0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mpc = 32'h0;
    run_instr(32'h00000463, 32'h0, 32'h0, 32'h0, 1'b1, 32'h4, 1, 1);

    chk("issue_count", hs_count, exp_issues);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
